// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped, write-through cache controller.
package cache_ctrl_pkg;

  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned INDEX_W    = 7;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_SEL_W = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StRdResp,
    StFill,
    StUpdate,
    StFillResp,
    StWrMem,
    StWrResp
  } state_e;

endpackage

// File: rtl/cache_fill_buf.sv
// Line-fill buffer: collects LINE_WORDS memory words in order behind a word counter.
module cache_fill_buf
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              load,
  input  logic [DATA_W-1:0]                 load_data,
  output logic [WORD_SEL_W-1:0]             cnt,
  output logic                              done,
  output logic [LINE_WORDS-1:0][DATA_W-1:0] line
);

  logic [WORD_SEL_W-1:0]             cnt_q;
  logic [LINE_WORDS-1:0][DATA_W-1:0] line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (load) begin
      line_q[cnt_q] <= load_data;
      cnt_q         <= cnt_q + WORD_SEL_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign done = load && (cnt_q == WORD_SEL_W'(LINE_WORDS - 1));
  assign line = line_q;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache controller: read-allocate line fills, write-through without allocate.
module cache_controller
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = cache_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cpu_req,
  input  logic                           cpu_we,
  input  logic [ADDR_W-1:0]              cpu_addr,
  input  logic [DATA_W-1:0]              cpu_wdata,
  output logic                           cpu_ready,
  output logic [DATA_W-1:0]              cpu_rdata,
  output logic                           cpu_busy,
  output logic [ADDR_W-1:0]              cache_addr,
  output logic                           cache_read_en,
  output logic                           cache_write_en,
  output logic [DATA_W-1:0]              cache_write_data,
  output logic                           cache_update,
  output logic [LINE_WORDS*DATA_W-1:0]   cache_update_data,
  input  logic [DATA_W-1:0]              cache_read_data,
  input  logic                           cache_valid,
  input  logic [ADDR_W-INDEX_W-1:0]      cache_tag,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ack,
  output logic [CNT_W-1:0]               hit_cnt,
  output logic [CNT_W-1:0]               miss_cnt
);

  state_e                            state_q, state_d;
  logic                              we_q;
  logic [ADDR_W-1:0]                 addr_q;
  logic [DATA_W-1:0]                 wdata_q;
  logic [CNT_W-1:0]                  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                              hit;
  logic                              fb_clear, fb_load, fb_done;
  logic [WORD_SEL_W-1:0]             fb_cnt;
  logic [LINE_WORDS-1:0][DATA_W-1:0] fb_line;

  cache_fill_buf #(
    .DATA_W (DATA_W)
  ) u_fill_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (fb_clear),
    .load      (fb_load),
    .load_data (mem_rdata),
    .cnt       (fb_cnt),
    .done      (fb_done),
    .line      (fb_line)
  );

  // Kept apart from the main decode so valid/tag lookup never loops back through it.
  assign cache_addr = (state_q inside {StLookup, StUpdate}) ? addr_q : '0;
  assign hit        = cache_valid && (cache_tag == addr_q[ADDR_W-1:INDEX_W]);
  assign cpu_busy   = (state_q != StIdle);
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (state_q == StIdle && cpu_req) begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == StLookup) begin
      if (hit) begin
        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else if (miss_cnt_q != '1) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    cpu_ready         = 1'b0;
    cpu_rdata         = '0;
    cache_read_en     = 1'b0;
    cache_write_en    = 1'b0;
    cache_write_data  = '0;
    cache_update      = 1'b0;
    cache_update_data = '0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = '0;
    fb_clear          = 1'b0;
    fb_load           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) state_d = StLookup;
      end
      StLookup: begin
        if (we_q) begin
          cache_write_en   = hit;
          cache_write_data = hit ? wdata_q : '0;
          state_d          = StWrMem;
        end else if (hit) begin
          cache_read_en = 1'b1;
          state_d       = StRdResp;
        end else begin
          fb_clear = 1'b1;
          state_d  = StFill;
        end
      end
      StRdResp: begin
        cpu_ready = 1'b1;
        cpu_rdata = cache_read_data;
        state_d   = StIdle;
      end
      StFill: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[ADDR_W-1:WORD_SEL_W], fb_cnt};
        fb_load  = mem_ack;
        if (fb_done) state_d = StUpdate;
      end
      StUpdate: begin
        cache_update      = 1'b1;
        cache_update_data = fb_line;
        state_d           = StFillResp;
      end
      StFillResp: begin
        // Serve the miss from the fill buffer; the array read port is not used here.
        cpu_ready = 1'b1;
        cpu_rdata = fb_line[addr_q[WORD_SEL_W-1:0]];
        state_d   = StIdle;
      end
      StWrMem: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack) state_d = StWrResp;
      end
      StWrResp: begin
        cpu_ready = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache array and memory, plus a transaction-level model.
module tb_cache_controller;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_req, cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic [DW-1:0]  cpu_wdata;
  logic           cpu_ready, cpu_busy;
  logic [DW-1:0]  cpu_rdata;
  logic [AW-1:0]  cache_addr;
  logic           cache_read_en, cache_write_en, cache_update;
  logic [DW-1:0]  cache_write_data, cache_read_data;
  logic [127:0]   cache_update_data;
  logic           cache_valid;
  logic [2:0]     cache_tag;
  logic           mem_req, mem_we, mem_ack;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;
  logic [15:0]    hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_controller #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_ready         (cpu_ready),
    .cpu_rdata         (cpu_rdata),
    .cpu_busy          (cpu_busy),
    .cache_addr        (cache_addr),
    .cache_read_en     (cache_read_en),
    .cache_write_en    (cache_write_en),
    .cache_write_data  (cache_write_data),
    .cache_update      (cache_update),
    .cache_update_data (cache_update_data),
    .cache_read_data   (cache_read_data),
    .cache_valid       (cache_valid),
    .cache_tag         (cache_tag),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt)
  );

  typedef struct {
    bit         we;
    logic [9:0] addr;
    logic [31:0] data;
  } mem_op_t;

  typedef struct {
    bit          we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    bit          exp_hit;
    logic [31:0] exp_rdata;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // External devices driven by the DUT
  logic [31:0] mem_dev [1024];
  bit          c_valid [32];
  logic [2:0]  c_tag   [32];
  logic [31:0] c_data  [32][4];
  mem_op_t     ops[$];
  int          cwe_cnt = 0;
  int          upd_cnt = 0;
  int          both_err = 0;
  logic [127:0] last_upd;

  // Reference model
  logic [31:0] ref_mem [1024];
  bit          ref_valid [32];
  logic [2:0]  ref_tag [32];
  int unsigned ref_hit, ref_miss;

  assign cache_valid = c_valid[cache_addr[6:2]];
  assign cache_tag   = c_tag[cache_addr[6:2]];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [9:0] a);
    return ref_valid[a[6:2]] && (ref_tag[a[6:2]] == a[9:7]);
  endfunction

  // Memory: acks one word two cycles after a request is seen.
  initial begin : mem_model
    int wait_cnt = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (reset || !mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt == 2) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        if (mem_we) mem_dev[mem_addr] = mem_wdata;
        else mem_rdata = mem_dev[mem_addr];
        ops.push_back('{mem_we, mem_addr, mem_wdata});
      end else begin
        wait_cnt++;
      end
    end
  end

  // Cache array: strobes sampled mid-cycle, applied just after the edge.
  initial begin : cache_model
    bit s_re, s_we, s_up;
    logic [9:0] s_addr;
    logic [31:0] s_wd;
    logic [127:0] s_ud;
    cache_read_data = '0;
    for (int i = 0; i < 32; i++) begin
      c_valid[i] = 1'b0;
      c_tag[i]   = '0;
      for (int k = 0; k < 4; k++) c_data[i][k] = '0;
    end
    forever begin
      @(negedge clk);
      s_re   = cache_read_en;
      s_we   = cache_write_en;
      s_up   = cache_update;
      s_addr = cache_addr;
      s_wd   = cache_write_data;
      s_ud   = cache_update_data;
      if (s_re && s_we) both_err++;
      @(posedge clk);
      #1;
      if (!reset) begin
        if (s_re) cache_read_data = c_data[s_addr[6:2]][s_addr[1:0]];
        if (s_we) begin
          c_data[s_addr[6:2]][s_addr[1:0]] = s_wd;
          cwe_cnt++;
        end
        if (s_up) begin
          c_valid[s_addr[6:2]] = 1'b1;
          c_tag[s_addr[6:2]]   = s_addr[9:7];
          for (int k = 0; k < 4; k++) c_data[s_addr[6:2]][k] = s_ud[k*32 +: 32];
          last_upd = s_ud;
          upd_cnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One CPU transaction from the IDLE negedge to one cycle after cpu_ready.
  task automatic run_txn(input bit we, input logic [9:0] a, input logic [31:0] wd, input bit noise,
                         input bit exp_hit, input logic [31:0] exp_rd, input string nm);
    int lat, exp_lat, exp_n, cwe0, upd0;
    logic [9:0] base;
    logic [127:0] exp_ud;
    logic [31:0] got_rd;
    bit got_ready;
    base = {a[9:2], 2'b00};
    for (int k = 0; k < 4; k++) exp_ud[k*32 +: 32] = ref_mem[base + 10'(k)];
    exp_n   = we ? 1 : (exp_hit ? 0 : 4);
    exp_lat = we ? 5 : (exp_hit ? 2 : 15);
    ops.delete();
    cwe0 = cwe_cnt;
    upd0 = upd_cnt;
    chk({nm, " idle before"}, cpu_busy, 1'b0);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = wd;
    @(negedge clk);
    lat = 1;
    cpu_req = noise;
    if (noise) begin
      cpu_we   = ~we;
      cpu_addr = 10'($urandom);
    end
    while (!cpu_ready && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 3) cpu_req = 1'b0;
    end
    cpu_req   = 1'b0;
    got_ready = cpu_ready;
    got_rd    = cpu_rdata;
    chk({nm, " ready"}, got_ready, 1'b1);
    chk({nm, " latency"}, lat, exp_lat);
    if (!we) chk({nm, " rdata"}, got_rd, exp_rd);
    @(negedge clk);
    chk({nm, " ready pulse"}, cpu_ready, 1'b0);
    chk({nm, " idle after"}, cpu_busy, 1'b0);
    // Advance the model
    if (exp_hit) begin
      if (ref_hit < 32'hFFFF) ref_hit++;
    end else if (ref_miss < 32'hFFFF) begin
      ref_miss++;
    end
    if (we) ref_mem[a] = wd;
    else if (!exp_hit) begin
      ref_valid[a[6:2]] = 1'b1;
      ref_tag[a[6:2]]   = a[9:7];
    end
    chk({nm, " hit_cnt"}, hit_cnt, ref_hit[15:0]);
    chk({nm, " miss_cnt"}, miss_cnt, ref_miss[15:0]);
    chk({nm, " mem ops"}, ops.size(), exp_n);
    for (int i = 0; i < ops.size() && i < exp_n; i++) begin
      chk($sformatf("%s op%0d we", nm, i), ops[i].we, we);
      chk($sformatf("%s op%0d addr", nm, i), ops[i].addr, we ? a : base + 10'(i));
      if (we) chk($sformatf("%s op%0d wdata", nm, i), ops[i].data, wd);
    end
    chk({nm, " cache writes"}, cwe_cnt - cwe0, (we && exp_hit) ? 1 : 0);
    chk({nm, " cache updates"}, upd_cnt - upd0, (!we && !exp_hit) ? 1 : 0);
    if (!we && !exp_hit) chk({nm, " update data"}, last_upd, exp_ud);
  endtask

  vec_t vecs[9];

  initial begin : main
    int guard, upd0;
    logic [9:0] a;
    bit rwe, noise;
    logic [31:0] wd;

    vecs[0] = '{1'b0, 10'h085, 32'h0,        1'b0, 32'h0000_0101};
    vecs[1] = '{1'b0, 10'h085, 32'h0,        1'b1, 32'h0000_0101};
    vecs[2] = '{1'b1, 10'h085, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 10'h385, 32'h1234_5678, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 10'h085, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 10'h386, 32'h0,        1'b0, 32'hA000_0386};
    vecs[6] = '{1'b0, 10'h385, 32'h0,        1'b1, 32'h1234_5678};
    vecs[7] = '{1'b0, 10'h087, 32'h0,        1'b0, 32'h0000_0103};
    vecs[8] = '{1'b0, 10'h084, 32'h0,        1'b1, 32'h0000_0100};

    for (int i = 0; i < 1024; i++) begin
      mem_dev[i] = 32'hA000_0000 | 32'(i);
      if (i >= 'h84 && i <= 'h87) mem_dev[i] = 32'h100 + 32'(i - 'h84);
      ref_mem[i] = mem_dev[i];
    end
    for (int i = 0; i < 32; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    ref_hit  = 0;
    ref_miss = 0;

    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", cpu_busy, 1'b0);
    chk("reset ready", cpu_ready, 1'b0);
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset strobes", {cache_read_en, cache_write_en, cache_update}, 3'b000);
    chk("reset hit_cnt", hit_cnt, 16'h0);
    chk("reset miss_cnt", miss_cnt, 16'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0, vecs[i].exp_hit, vecs[i].exp_rdata,
              $sformatf("vec%0d", i));

    // Reset in the middle of a line fill
    ops.delete();
    upd0      = upd_cnt;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 10'h200;
    @(negedge clk);
    cpu_req = 1'b0;
    guard = 0;
    while (ops.size() < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rstfill two acks", ops.size(), 2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("rstfill mem_req", mem_req, 1'b0);
    chk("rstfill busy", cpu_busy, 1'b0);
    chk("rstfill mem_addr", mem_addr, 10'h0);
    chk("rstfill hit_cnt", hit_cnt, 16'h0);
    chk("rstfill miss_cnt", miss_cnt, 16'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("rstfill no update", upd_cnt - upd0, 0);
    chk("rstfill stays idle", cpu_busy, 1'b0);
    ref_hit  = 0;
    ref_miss = 0;
    run_txn(1'b0, 10'h200, 32'h0, 1'b0, 1'b0, 32'hA000_0200, "refill");

    // Randomised traffic, with cpu_req pulses while busy on some transactions
    for (int i = 0; i < 120; i++) begin
      a     = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rwe   = ($urandom_range(0, 2) == 0);
      wd    = $urandom;
      noise = ($urandom_range(0, 3) == 0);
      run_txn(rwe, a, wd, noise, model_hit(a), ref_mem[a], $sformatf("rnd%0d", i));
    end

    // Hit counter saturation
    force dut.hit_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_q;
    ref_hit = 32'hFFFF;
    chk("sat preset", hit_cnt, 16'hFFFF);
    a = {ref_tag[0], 7'd0};
    run_txn(1'b0, a, 32'h0, 1'b1, model_hit(a), ref_mem[a], "sat hit");

    chk("read/write strobe overlap", both_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
